regfile_sb: RTL and testbench

- Parametrised successor to the decode-stage register file: N read ports, one write-back port, and a per-register busy scoreboard.
- Sits in DECODE. Supplies operands to ID/EX, bypasses same-cycle write-back data, and raises a stall request when an operand's producer has not written back yet.
- The stall request is consumed by the hazard unit.
- Generalises the fixed 2-read, 32x32 file to configurable width, depth and read-port count.

---
 rtl/regfile_sb.sv | 122 ++++++++++++
 tb/tb_regfile_sb.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: decode-stage register file with a per-register busy scoreboard.
//   NRD combinational read ports, one write-back port, and a stall request
//   raised when a needed operand still has an outstanding producer.
//   Optional macro REGFILE_SB_BYPASS_EN: when defined, a same-cycle
//   write-back is forwarded to the read ports and clears the hazard. When it
//   is undefined, reads see stored contents only, and the stall lasts one
//   extra cycle until the write has landed.
// Ports:
//   CLK, RSTn          clock, async active-low reset
//   EN, START          qualify every state update
//   rs_addr, rs_used   per-port read address and operand-needed flag
//   rd_data            per-port read data (port i at [i*XLEN +: XLEN])
//   wb_we/addr/data    write-back
//   iss_valid/we/rd    issuing instruction's destination claim
//   stall, busy_vec    hazard request, scoreboard state

// One read port: operand select plus that port's hazard term.
module regfile_sb_lane #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic [NREG-1:0][XLEN-1:0] regs,
  input  logic [NREG-1:0]           busy,
  input  logic [AW-1:0]             addr,
  input  logic                      used,
  input  logic                      wb_we,
  input  logic [AW-1:0]             wb_addr,
  input  logic [XLEN-1:0]           wb_data,
  output logic [XLEN-1:0]           data,
  output logic                      hazard
);
  logic nz;
  assign nz = (addr != '0);

`ifdef REGFILE_SB_BYPASS_EN
  logic wb_hit;
  assign wb_hit = wb_we && (wb_addr == addr);
  // Forwarded data also resolves the hazard, so no bubble is taken.
  assign data   = !nz ? '0 : (wb_hit ? wb_data : regs[addr]);
  assign hazard = used && nz && busy[addr] && !wb_hit;
`else
  // Without forwarding the write-back ports are not looked at here.
  logic unused_wb;
  assign unused_wb = ^{wb_we, wb_addr, wb_data};
  assign data   = nz ? regs[addr] : '0;
  assign hazard = used && nz && busy[addr];
`endif
endmodule

module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                EN,
  input  logic                START,
  input  logic [NRD*AW-1:0]   rs_addr,
  input  logic [NRD-1:0]      rs_used,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wb_we,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                iss_valid,
  input  logic                iss_we,
  input  logic [AW-1:0]       iss_rd,
  output logic                stall,
  output logic [NREG-1:0]     busy_vec
);
  logic [NREG-1:0][XLEN-1:0] regs;
  logic [NREG-1:0]           busy, busy_nxt;
  logic [NRD-1:0]            hz;
  logic                      upd, wr, set;

  assign upd = EN && START;
  // Register 0 is never written and never claimed, so it reads as 0 and
  // its busy bit stays low without any extra masking.
  assign wr  = upd && wb_we && (wb_addr != '0);
  // A stalled instruction does not issue, so it must not claim its rd.
  assign set = upd && iss_valid && iss_we && (iss_rd != '0) && !stall;

  genvar g;
  generate
    for (g = 0; g < NRD; g++) begin : g_rd
      regfile_sb_lane #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_lane (
        .regs    (regs),
        .busy    (busy),
        .addr    (rs_addr[g*AW +: AW]),
        .used    (rs_used[g]),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .data    (rd_data[g*XLEN +: XLEN]),
        .hazard  (hz[g])
      );
    end
  endgenerate

  assign stall    = |hz;
  assign busy_vec = busy;

  // Clear first, then set: when both hit one register the new producer
  // supersedes the one writing back.
  always_comb begin
    busy_nxt = busy;
    if (wr)  busy_nxt[wb_addr] = 1'b0;
    if (set) busy_nxt[iss_rd]  = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      regs <= '0;
      busy <= '0;
    end else if (upd) begin
      if (wr) regs[wb_addr] <= wb_data;
      busy <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of regfile_sb against a
// behavioural array/scoreboard model (NRD=3, XLEN=64, NREG=16 build).
module tb_regfile_sb;
  localparam int XLEN = 64;
  localparam int NREG = 16;
  localparam int NRD  = 3;
  localparam int AW   = 4;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                CLK = 1'b0;
  logic                RSTn, EN, START;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD-1:0]      rs_used;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wb_we;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                iss_valid, iss_we;
  logic [AW-1:0]       iss_rd;
  logic                stall;
  logic [NREG-1:0]     busy_vec;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .CLK(CLK), .RSTn(RSTn), .EN(EN), .START(START),
    .rs_addr(rs_addr), .rs_used(rs_used), .rd_data(rd_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_valid(iss_valid), .iss_we(iss_we), .iss_rd(iss_rd),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 CLK = ~CLK;

  int nchk = 0;
  int nerr = 0;

  // reference model
  logic [XLEN-1:0] mreg [NREG];
  bit              mbusy [NREG];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < NREG; i++) begin
      mreg[i]  = '0;
      mbusy[i] = 1'b0;
    end
  endtask

  function automatic logic [XLEN-1:0] m_read(input logic [AW-1:0] a);
    if (a == 0) return '0;
    if (BYP && wb_we && wb_addr == a) return wb_data;
    return mreg[a];
  endfunction

  function automatic bit m_stall();
    for (int i = 0; i < NRD; i++) begin
      logic [AW-1:0] a;
      a = rs_addr[i*AW +: AW];
      if (rs_used[i] && a != 0 && mbusy[a] && !(BYP && wb_we && wb_addr == a))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [NREG-1:0] m_busyvec();
    logic [NREG-1:0] v;
    for (int i = 0; i < NREG; i++) v[i] = mbusy[i];
    return v;
  endfunction

  task automatic check_all(input string tag);
    for (int i = 0; i < NRD; i++)
      chk($sformatf("%s_rd%0d", tag, i), rd_data[i*XLEN +: XLEN], m_read(rs_addr[i*AW +: AW]));
    chk({tag, "_stall"}, {63'd0, stall}, {63'd0, m_stall()});
    chk({tag, "_busy"}, {48'd0, busy_vec}, {48'd0, m_busyvec()});
  endtask

  // Called at a negedge with inputs already driven: check, clock, advance model.
  task automatic tick(input string tag);
    bit st;
    #1 check_all(tag);
    st = m_stall();
    @(posedge CLK);
    if (RSTn && EN && START) begin
      if (wb_we && wb_addr != 0) begin
        mreg[wb_addr]  = wb_data;
        mbusy[wb_addr] = 1'b0;
      end
      if (iss_valid && iss_we && iss_rd != 0 && !st) mbusy[iss_rd] = 1'b1;
    end
    @(negedge CLK);
  endtask

  task automatic idle();
    EN = 1'b1; START = 1'b1;
    rs_addr = '0; rs_used = '0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    iss_valid = 1'b0; iss_we = 1'b0; iss_rd = '0;
  endtask

  task automatic set_rs(input int i, input logic [AW-1:0] a, input bit u);
    rs_addr[i*AW +: AW] = a;
    rs_used[i] = u;
  endtask

  task automatic do_wb(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic do_iss(input logic [AW-1:0] a);
    iss_valid = 1'b1; iss_we = 1'b1; iss_rd = a;
  endtask

  initial begin
    m_clear();
    RSTn = 1'b0;
    idle();
    @(negedge CLK);
    check_all("reset");
    chk("reset_busy", {48'd0, busy_vec}, 64'd0);
    RSTn = 1'b1;
    #1 chk("reset_stall", {63'd0, stall}, 64'd0);

    // write then read back; x0 ignores writes
    idle(); do_wb(5, 64'hDEADBEEF); tick("wr5");
    idle(); set_rs(0, 5, 1'b0);
    #1 chk("rd5", rd_data[0 +: XLEN], 64'hDEADBEEF);
    tick("rd5t");
    idle(); do_wb(0, 64'h1234); tick("wr0");
    idle(); set_rs(0, 0, 1'b1);
    #1 chk("rd0", rd_data[0 +: XLEN], 64'd0);
    tick("rd0t");

    // same-cycle write-back to a busy x7 read on port 1
    idle(); do_iss(7); tick("iss7");
    idle(); do_wb(7, 64'hA5A5A5A5); set_rs(1, 7, 1'b1);
`ifdef REGFILE_SB_BYPASS_EN
    #1 chk("byp7_data", rd_data[XLEN +: XLEN], 64'hA5A5A5A5);
    chk("byp7_stall", {63'd0, stall}, 64'd0);
`else
    #1 chk("nobyp7_stall", {63'd0, stall}, 64'd1);
    chk("nobyp7_data", rd_data[XLEN +: XLEN], 64'd0);
`endif
    tick("byp7t");
    idle(); set_rs(1, 7, 1'b1);
    #1 chk("after7_data", rd_data[XLEN +: XLEN], 64'hA5A5A5A5);
    chk("after7_stall", {63'd0, stall}, 64'd0);
    tick("after7t");

    // RAW hazard on x3
    idle(); do_iss(3); tick("iss3");
    idle(); set_rs(0, 3, 1'b1);
    #1 chk("raw3_stall", {63'd0, stall}, 64'd1);
    chk("raw3_busy", {63'd0, busy_vec[3]}, 64'd1);
    tick("raw3t");
    idle(); set_rs(0, 3, 1'b1); do_wb(3, 64'h0123_4567_89AB_CDEF);
    #1 chk("wb3_stall", {63'd0, stall}, BYP ? 64'd0 : 64'd1);
    tick("wb3t");
    idle(); set_rs(0, 3, 1'b1);
    #1 chk("clr3_busy", {63'd0, busy_vec[3]}, 64'd0);
    chk("clr3_data", rd_data[0 +: XLEN], 64'h0123_4567_89AB_CDEF);
    tick("clr3t");

    // set wins over clear on x9; unused operand never stalls
    idle(); do_iss(9); tick("iss9");
    idle(); do_iss(9); do_wb(9, 64'h99); tick("setclr9");
    idle(); set_rs(0, 9, 1'b0);
    #1 chk("set9_busy", {63'd0, busy_vec[9]}, 64'd1);
    chk("unused9_stall", {63'd0, stall}, 64'd0);
    tick("unused9t");
    idle(); do_wb(9, 64'h9A); tick("clr9");

    // EN=0 freezes file and scoreboard
    idle(); EN = 1'b0; do_wb(4, 64'h4444); do_iss(6); tick("en0");
    idle(); set_rs(0, 4, 1'b1);
    #1 chk("en0_x4", rd_data[0 +: XLEN], 64'd0);
    chk("en0_busy", {48'd0, busy_vec}, 64'd0);
    tick("en0t");

    // async reset with busy = x3|x6
    idle(); do_iss(3); tick("iss3b");
    idle(); do_iss(6); tick("iss6");
    idle();
    #1 chk("pre_rst_busy", {48'd0, busy_vec}, 64'h48);
    RSTn = 1'b0;
    #1 chk("async_rst_busy", {48'd0, busy_vec}, 64'd0);
    m_clear();
    tick("in_rst");
    RSTn = 1'b1;

    // three concurrent 64-bit reads
    idle(); do_wb(10, 64'h1111_2222_3333_4444); tick("w10");
    idle(); do_wb(11, 64'h5555_6666_7777_8888); tick("w11");
    idle(); do_wb(12, 64'h9999_AAAA_BBBB_CCCC); tick("w12");
    idle(); set_rs(0, 10, 1'b1); set_rs(1, 11, 1'b1); set_rs(2, 12, 1'b1);
    #1 chk("tri_rd0", rd_data[0 +: XLEN], 64'h1111_2222_3333_4444);
    chk("tri_rd1", rd_data[XLEN +: XLEN], 64'h5555_6666_7777_8888);
    chk("tri_rd2", rd_data[2*XLEN +: XLEN], 64'h9999_AAAA_BBBB_CCCC);
    tick("trit");

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      EN        = ($urandom_range(0, 9) != 0);
      START     = ($urandom_range(0, 15) != 0);
      rs_addr   = NRD*AW'($urandom);
      rs_used   = NRD'($urandom);
      wb_we     = $urandom_range(0, 1);
      wb_addr   = AW'($urandom);
      wb_data   = {$urandom, $urandom};
      iss_valid = $urandom_range(0, 1);
      iss_we    = ($urandom_range(0, 3) != 0);
      iss_rd    = AW'($urandom);
      // steer some reads at the write-back target to exercise forwarding
      if ($urandom_range(0, 3) == 0) rs_addr[AW-1:0] = wb_addr;
      if ($urandom_range(0, 99) == 0) begin
        RSTn = 1'b0;
        m_clear();
        tick("rand_rst");
        RSTn = 1'b1;
      end else begin
        tick("rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
